spike_readout_argmax: RTL

SPIKE_READOUT_ARGMAX -- requirements
Module: spike_readout_argmax

---
 rtl/spike_readout_argmax_pkg.sv | 18 +
 rtl/sat_counter.sv | 39 +++
 rtl/spike_readout_argmax.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/spike_readout_argmax_pkg.sv
// Shared definitions for the spike readout: FSM state encoding, default sizing constants
// and the class-index width.
package spike_readout_argmax_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StScan,
        StDone
    } state_e;

    localparam int unsigned DefNumClasses   = 10;
    localparam int unsigned DefWidth        = 8;
    localparam int unsigned DefWindowCycles = 64;
    localparam int unsigned ClassIdxW       = $clog2(DefNumClasses);
    localparam int unsigned WinCntW         = 16;

endpackage

// File: rtl/sat_counter.sv
// WIDTH_P-bit saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
    import spike_readout_argmax_pkg::*;
#(
    parameter int unsigned WIDTH_P = DefWidth
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [WIDTH_P-1:0] count_o
);

    localparam logic [WIDTH_P-1:0] CntMax = '1;

    logic [WIDTH_P-1:0] count_q, count_d;

    // Next count: clear wins over increment; increment stops at the ceiling.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CntMax)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/spike_readout_argmax.sv
// Spike-count readout: integrates per-class spikes over a fixed window, then scans the
// counters one class per cycle to find the winner (ties go to the lowest index).
// Optional build macro SPIKE_READOUT_MARGIN_EN adds margin_o (winner minus runner-up).
module spike_readout_argmax
    import spike_readout_argmax_pkg::*;
#(
    parameter int unsigned NUM_CLASSES   = DefNumClasses,
    parameter int unsigned WIDTH_P       = DefWidth,
    parameter int unsigned WINDOW_CYCLES = DefWindowCycles
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_CLASSES-1:0]         spike_i,
    input  logic                           start_i,
    input  logic                           ready_i,
    output logic                           busy_o,
    output logic                           valid_o,
    output logic [$clog2(NUM_CLASSES)-1:0] class_o,
    output logic [WIDTH_P-1:0]             count_o,
    output logic                           no_spike_o
`ifdef SPIKE_READOUT_MARGIN_EN
    ,
    output logic [WIDTH_P-1:0]             margin_o
`endif
);

    localparam int unsigned      ClassW  = $clog2(NUM_CLASSES);
    localparam logic [WinCntW-1:0] WinLast = WinCntW'(WINDOW_CYCLES - 1);
    localparam logic [ClassW-1:0]  IdxLast = ClassW'(NUM_CLASSES - 1);

    state_e              state_q;
    logic [WinCntW-1:0]  win_q;
    logic [ClassW-1:0]   idx_q;
    logic [ClassW-1:0]   best_idx_q, best_idx_d;
    logic [WIDTH_P-1:0]  best_cnt_q, best_cnt_d;
    logic                busy_q, valid_q, no_spike_q;
    logic [ClassW-1:0]   class_q;
    logic [WIDTH_P-1:0]  count_q;

    logic                cnt_clr, cnt_en, take;
    logic [WIDTH_P-1:0]  cand_cnt;
    logic [WIDTH_P-1:0]  cnt [NUM_CLASSES];

    assign cnt_clr = (state_q == StIdle) && start_i;
    assign cnt_en  = (state_q == StCount);

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cnt
        sat_counter #(
            .WIDTH_P (WIDTH_P)
        ) u_cnt (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clr_i   (cnt_clr),
            .inc_i   (cnt_en & spike_i[k]),
            .count_o (cnt[k])
        );
    end

    // Scan step: strictly-greater compare keeps the lowest index on ties.
    always_comb begin
        cand_cnt   = cnt[idx_q];
        take       = cand_cnt > best_cnt_q;
        best_idx_d = take ? idx_q : best_idx_q;
        best_cnt_d = take ? cand_cnt : best_cnt_q;
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            win_q      <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            class_q    <= '0;
            count_q    <= '0;
            no_spike_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StCount;
                        win_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StCount: begin
                    win_q <= win_q + WinCntW'(1);
                    if (win_q == WinLast) begin
                        state_q    <= StScan;
                        idx_q      <= '0;
                        best_idx_q <= '0;
                        best_cnt_q <= '0;
                    end
                end
                StScan: begin
                    best_idx_q <= best_idx_d;
                    best_cnt_q <= best_cnt_d;
                    idx_q      <= idx_q + ClassW'(1);
                    if (idx_q == IdxLast) begin
                        state_q    <= StDone;
                        valid_q    <= 1'b1;
                        class_q    <= best_idx_d;
                        count_q    <= best_cnt_d;
                        no_spike_q <= (best_cnt_d == '0);
                    end
                end
                StDone: begin
                    if (ready_i) begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign class_o    = class_q;
    assign count_o    = count_q;
    assign no_spike_o = no_spike_q;

`ifdef SPIKE_READOUT_MARGIN_EN
    logic [WIDTH_P-1:0] second_q, second_d, margin_q;

    // Runner-up: a displaced best becomes second; a tie with best also lands here.
    always_comb begin
        second_d = second_q;
        if (take) begin
            second_d = best_cnt_q;
        end else if (cand_cnt > second_q) begin
            second_d = cand_cnt;
        end
    end

    // Runner-up tracking and margin register, latched together with the result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            second_q <= '0;
            margin_q <= '0;
        end else if ((state_q == StCount) && (win_q == WinLast)) begin
            second_q <= '0;
        end else if (state_q == StScan) begin
            second_q <= second_d;
            if (idx_q == IdxLast) begin
                margin_q <= best_cnt_d - second_d;
            end
        end
    end

    assign margin_o = margin_q;
`else
    // Only the single best class is tracked.
`endif

endmodule
